// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//   Receive-side PRBS/LFSR checker. It self-synchronises to an incoming PRBS
//   stream, then free-runs a local LFSR and counts bit errors against it.
//   One DATA_WIDTH beat is consumed on every cycle with s_valid=1.
//
// Parameters
//   DATA_WIDTH    bits per beat
//   POLY_WIDTH    LFSR degree
//   POLY          tap vector: POLY[i]=1 means term x^(i+1); x^0 is implicit
//   LOCK_COUNT    consecutive clean, non-degenerate beats needed to lock
//   LOSS_COUNT    consecutive errored beats (while locked) that drop lock
//   ERR_CNT_WIDTH width of err_count
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   s_valid    in   beat valid (no backpressure)
//   s_data     in   beat, s_data[0] is the earliest bit in time
//   clr_err    in   synchronous clear of err_count
//   locked     out  1 while locked to the stream
//   err_pulse  out  1-cycle pulse: previous beat had >=1 bit error while locked
//   err_count  out  saturating bit-error count accumulated while locked
// -----------------------------------------------------------------------------
module lfsr_checker #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    POLY_WIDTH    = 7,
    parameter logic [POLY_WIDTH-1:0] POLY          = 7'b1100000,
    parameter int                    LOCK_COUNT    = 16,
    parameter int                    LOSS_COUNT    = 4,
    parameter int                    ERR_CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     clr_err,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int ERRW = $clog2(DATA_WIDTH + 1);
    localparam int GW   = $clog2(LOCK_COUNT + 1);
    localparam int BW   = $clog2(LOSS_COUNT + 1);
    localparam int SUMW = ((ERR_CNT_WIDTH > ERRW) ? ERR_CNT_WIDTH : ERRW) + 1;
    localparam logic [SUMW-1:0] SUM_MAX =
        {{(SUMW-ERR_CNT_WIDTH){1'b0}}, {ERR_CNT_WIDTH{1'b1}}};

    typedef enum logic {
        ST_SEEK,
        ST_LOCKED
    } state_t;

    state_t                   r_state;
    logic [POLY_WIDTH-1:0]    r_sr;
    logic [GW-1:0]            r_good;
    logic [BW-1:0]            r_bad;
    logic                     r_pulse;
    logic [ERR_CNT_WIDTH-1:0] r_cnt;

    state_t                   w_state_nxt;
    logic [POLY_WIDTH-1:0]    w_sr_nxt;
    logic [GW-1:0]            w_good_nxt;
    logic [BW-1:0]            w_bad_nxt;
    logic                     w_pulse_nxt;
    logic [ERR_CNT_WIDTH-1:0] w_cnt_nxt;

    // Two parallel unrolled chains over the beat: one fed with received bits
    // (self-sync / reload) and one fed with its own predictions (free-run).
    logic [POLY_WIDTH-1:0]    w_sr_rx;
    logic [POLY_WIDTH-1:0]    w_sr_gen;
    logic                     w_rx_mism;
    logic [ERRW-1:0]          w_errs;
    logic                     w_pred_rx;
    logic                     w_pred_gen;
    logic [SUMW-1:0]          w_sum;
    logic [ERR_CNT_WIDTH-1:0] w_cnt_base;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        w_sr_rx    = r_sr;
        w_sr_gen   = r_sr;
        w_rx_mism  = 1'b0;
        w_errs     = '0;
        w_pred_rx  = 1'b0;
        w_pred_gen = 1'b0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            w_pred_rx  = ^(w_sr_rx & POLY);
            w_rx_mism  = w_rx_mism | (w_pred_rx ^ s_data[j]);
            w_sr_rx    = {w_sr_rx[POLY_WIDTH-2:0], s_data[j]};

            w_pred_gen = ^(w_sr_gen & POLY);
            w_errs     = w_errs + ERRW'(w_pred_gen ^ s_data[j]);
            w_sr_gen   = {w_sr_gen[POLY_WIDTH-2:0], w_pred_gen};
        end
    end

    // Clear happens before the add so clr_err with an errored beat loads errs.
    always_comb begin
        w_cnt_base = clr_err ? '0 : r_cnt;
        w_sum      = SUMW'(w_cnt_base) + SUMW'(w_errs);
        if (w_sum > SUM_MAX) begin
            w_sum = SUM_MAX;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_pulse_nxt = 1'b0;
        w_cnt_nxt   = w_cnt_base;

        if (s_valid) begin
            case (r_state)
                ST_SEEK: begin
                    w_sr_nxt = w_sr_rx;
                    // An all-zero history predicts all zeros trivially, so it
                    // never counts toward lock.
                    if (!w_rx_mism && (r_sr != '0)) begin
                        if (r_good == GW'(LOCK_COUNT - 1)) begin
                            w_state_nxt = ST_LOCKED;
                            w_good_nxt  = '0;
                            w_bad_nxt   = '0;
                        end else begin
                            w_good_nxt = r_good + GW'(1);
                        end
                    end else begin
                        w_good_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    w_sr_nxt = w_sr_gen;
                    if (w_errs != '0) begin
                        w_pulse_nxt = 1'b1;
                        w_cnt_nxt   = w_sum[ERR_CNT_WIDTH-1:0];
                        if (r_bad == BW'(LOSS_COUNT - 1)) begin
                            // Drop lock and restart sync from what was received.
                            w_state_nxt = ST_SEEK;
                            w_sr_nxt    = w_sr_rx;
                            w_bad_nxt   = '0;
                        end else begin
                            w_bad_nxt = r_bad + BW'(1);
                        end
                    end else begin
                        w_bad_nxt = '0;
                    end
                end
                default: w_state_nxt = ST_SEEK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SEEK;
            r_sr    <= '0;
            r_good  <= '0;
            r_bad   <= '0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_good  <= w_good_nxt;
            r_bad   <= w_bad_nxt;
            r_pulse <= w_pulse_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign locked    = (r_state == ST_LOCKED);
    assign err_pulse = r_pulse;
    assign err_count = r_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

    localparam int         DW   = 8;
    localparam int         PW   = 7;
    localparam logic [6:0] TB_POLY = 7'b1100000;
    localparam int         LOCK = 16;
    localparam int         LOSS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        clr_err;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [31:0] err_count;
    logic [3:0]  err_count4;

    always #5 clk = ~clk;

    lfsr_checker #(
        .DATA_WIDTH(DW), .POLY_WIDTH(PW), .POLY(TB_POLY),
        .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count)
    );

    lfsr_checker #(
        .DATA_WIDTH(DW), .POLY_WIDTH(PW), .POLY(TB_POLY),
        .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_CNT_WIDTH(4)
    ) dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .clr_err(clr_err), .locked(locked4), .err_pulse(err_pulse4),
        .err_count(err_count4)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus source: PRBS7 x^7+x^6+1 bit stream -----------
    bit g_hist[$];   // g_hist[k] = bit (k+1) positions ago

    task automatic gen_beat(output logic [7:0] d);
        bit b;
        for (int j = 0; j < DW; j++) begin
            b = g_hist[5] ^ g_hist[6];
            g_hist.push_front(b);
            void'(g_hist.pop_back());
            d[j] = b;
        end
    endtask

    // ---------------- reference model ----------------------------------------
    bit      m_locked;
    int      m_good, m_bad;
    bit      m_pulse;
    longint  m_c32, m_c4;
    bit      m_hist[$];  // m_hist[k] = bit (k+1) positions ago in the checker's view

    function automatic bit predict(bit h[$]);
        bit p = 0;
        for (int i = 0; i < PW; i++) if (TB_POLY[i]) p ^= h[i];
        return p;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_good = 0; m_bad = 0; m_pulse = 0; m_c32 = 0; m_c4 = 0;
        m_hist = {};
        for (int i = 0; i < PW; i++) m_hist.push_back(1'b0);
    endtask

    task automatic model_beat(input logic [7:0] d, input logic v, input logic c);
        bit rx_hist[$];
        bit clean, nz, p;
        int errs;
        m_pulse = 0;
        if (c) begin m_c32 = 0; m_c4 = 0; end
        if (!v) return;
        if (!m_locked) begin
            nz = 0;
            foreach (m_hist[i]) nz |= m_hist[i];
            clean = 1;
            for (int j = 0; j < DW; j++) begin
                p = predict(m_hist);
                if (p != d[j]) clean = 0;
                m_hist.push_front(d[j]);
                void'(m_hist.pop_back());
            end
            if (clean && nz) begin
                m_good++;
                if (m_good == LOCK) begin m_locked = 1; m_good = 0; m_bad = 0; end
            end else m_good = 0;
        end else begin
            rx_hist = m_hist;
            errs = 0;
            for (int j = 0; j < DW; j++) begin
                p = predict(m_hist);
                if (p != d[j]) errs++;
                m_hist.push_front(p);
                void'(m_hist.pop_back());
                rx_hist.push_front(d[j]);
                void'(rx_hist.pop_back());
            end
            if (errs > 0) begin
                m_pulse = 1;
                m_c32 = m_c32 + errs; if (m_c32 > 64'hFFFF_FFFF) m_c32 = 64'hFFFF_FFFF;
                m_c4  = m_c4 + errs;  if (m_c4 > 15) m_c4 = 15;
                m_bad++;
                if (m_bad == LOSS) begin m_locked = 0; m_hist = rx_hist; m_bad = 0; end
            end else m_bad = 0;
        end
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".locked"},     64'(locked),     64'(m_locked));
        check({ph, ".err_pulse"},  64'(err_pulse),  64'(m_pulse));
        check({ph, ".err_count"},  64'(err_count),  64'(m_c32));
        check({ph, ".err_count4"}, 64'(err_count4), 64'(m_c4));
    endtask

    task automatic step(input string ph, input logic [7:0] d, input logic v, input logic c);
        @(negedge clk);
        s_data = d; s_valid = v; clr_err = c;
        @(posedge clk);
        model_beat(d, v, c);
        #1;
        check_outputs(ph);
    endtask

    task automatic clean_beat(input string ph);
        logic [7:0] d;
        gen_beat(d);
        step(ph, d, 1'b1, 1'b0);
    endtask

    task automatic gap(input string ph, input int n);
        for (int i = 0; i < n; i++) step(ph, 8'h00, 1'b0, 1'b0);
    endtask

    // ---------------- directed sequence ---------------------------------------
    initial begin
        logic [7:0] d;
        int         lock_beat;

        for (int i = 0; i < PW; i++) g_hist.push_back(1'b1);   // seed 7'h7F
        rst = 1'b1; s_valid = 1'b0; s_data = '0; clr_err = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Clean stream: lock must come from valid beats alone.
        lock_beat = -1;
        for (int b = 1; b <= 24; b++) begin
            clean_beat("acq");
            if (locked && lock_beat < 0) lock_beat = b;
        end
        check("acq.locked_final", 64'(locked), 64'd1);
        check("acq.no_errors", 64'(err_count), 64'd0);

        // One flipped bit in a locked beat counts exactly once.
        gen_beat(d);
        step("flip3", d ^ 8'h08, 1'b1, 1'b0);
        check("flip3.count", 64'(err_count), 64'd1);
        check("flip3.pulse", 64'(err_pulse), 64'd1);
        clean_beat("flip3");
        check("flip3.pulse_gone", 64'(err_pulse), 64'd0);
        check("flip3.still_locked", 64'(locked), 64'd1);

        // 20 single-bit errors separated by clean beats: 4-bit counter saturates.
        for (int k = 0; k < 20; k++) begin
            gen_beat(d);
            step("sat", d ^ (8'h01 << $urandom_range(0, DW - 1)), 1'b1, 1'b0);
            clean_beat("sat");
        end
        check("sat.count32", 64'(err_count), 64'd21);
        check("sat.count4", 64'(err_count4), 64'd15);

        // Clear together with an errored beat loads that beat's errors.
        gen_beat(d);
        step("clr", d ^ (8'h01 << $urandom_range(0, DW - 1)), 1'b1, 1'b1);
        check("clr.count32", 64'(err_count), 64'd1);
        check("clr.count4", 64'(err_count4), 64'd1);

        // Four inverted beats drop lock; clean stream with gaps relocks.
        for (int k = 0; k < 4; k++) begin
            gen_beat(d);
            step("loss", ~d, 1'b1, 1'b0);
        end
        check("loss.unlocked", 64'(locked), 64'd0);
        for (int k = 0; k < 30; k++) begin
            clean_beat("relock");
            gap("relock_gap", $urandom_range(0, 5));
        end
        check("relock.locked", 64'(locked), 64'd1);

        // Random error injection while locked (may drop and regain lock).
        for (int k = 0; k < 60; k++) begin
            gen_beat(d);
            if ($urandom_range(0, 3) == 0) d = d ^ 8'($urandom);
            step("rand", d, 1'b1, 1'b0);
            gap("rand_gap", $urandom_range(0, 2));
        end
        for (int k = 0; k < 25; k++) clean_beat("prelock");
        check("prelock.locked", 64'(locked), 64'd1);

        // Async reset while locked: outputs drop without waiting for an edge.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // All-zero stream must never lock.
        for (int k = 0; k < 40; k++) step("zeros", 8'h00, 1'b1, 1'b0);
        check("zeros.never_locked", 64'(locked), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
